// File: rtl/hidden_cpu_sequencer.sv
// Program store and run controller for the HiddenCPU core.
// Optional single-step in HALT: define HIDDEN_SEQ_STEP_EN.
module hidden_cpu_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int MAX_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [5:0] load_data,
    input  logic       load_last,
    input  logic       start,
    input  logic       halt_req,
    input  logic       step,
    input  logic [7:0] pc_in,
    output logic [5:0] instr,
    output logic       cpu_rst,
    output logic       cpu_clk_en,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] cycles
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [7:0] MAXC = 8'(MAX_CYCLES);

    typedef enum logic [2:0] {
        IDLE, RESET_CORE, RUN, HALT, DONE
    } state_t;

    state_t           state;
    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] prog_len;

    logic load_fire, pc_end, at_max, run_go, step_req, step_go;

    assign load_ready = (state == IDLE || state == DONE)
                      && (wr_ptr < PTR_W'(DEPTH));
    assign load_fire  = load_valid && load_ready;
    assign pc_end     = pc_in >= 8'(prog_len);
    assign at_max     = cycles == MAXC;
    assign run_go     = (state == RUN) && !pc_end && !at_max && !halt_req;

`ifdef HIDDEN_SEQ_STEP_EN
    // a resume request wins over a step on the same cycle
    assign step_req = (state == HALT) && step && !(start && !halt_req);
`else
    logic step_unused;
    assign step_unused = step;
    assign step_req    = 1'b0;
`endif

    assign step_go    = step_req && !pc_end && !at_max;
    assign cpu_rst    = state == RESET_CORE;
    assign cpu_clk_en = cpu_rst || run_go || step_go;
    assign instr      = (state == RUN || state == HALT || state == DONE)
                      ? mem[pc_in[ADDR_W-1:0]] : 6'b0;

    always_ff @(posedge clk) begin
        if (load_fire)
            mem[wr_ptr[ADDR_W-1:0]] <= load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            prog_len <= '0;
            cycles   <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load_fire) begin
                if (load_last || wr_ptr == PTR_W'(DEPTH - 1)) begin
                    prog_len <= wr_ptr + 1'b1;
                    wr_ptr   <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if ((run_go || step_go) && cycles != 8'hff)
                cycles <= cycles + 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (start && prog_len != '0) begin
                        state   <= RESET_CORE;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        cycles  <= '0;
                        timeout <= 1'b0;
                    end
                end
                RESET_CORE: state <= RUN;
                RUN: begin
                    if (pc_end || at_max) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !pc_end;
                    end else if (halt_req) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (!halt_req && start) begin
                        state <= RUN;
                    end else if (step_req && (pc_end || at_max)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !pc_end;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Directed bench for hidden_cpu_sequencer with a simple core PC model.
// Covers load, run, timeout, halt/resume, step and async reset.
module tb_hidden_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [5:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic       step = 1'b0;
    logic [7:0] pc = '0;
    logic [5:0] instr;
    logic       cpu_rst, cpu_clk_en, busy, done, timeout;
    logic [7:0] cycles;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int base;
    logic stuck = 1'b0;

    hidden_cpu_sequencer dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .start(start), .halt_req(halt_req), .step(step),
        .pc_in(pc), .instr(instr),
        .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en),
        .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_clk_en) begin
            if (cpu_rst) pc <= '0;
            else begin
                en_cnt <= en_cnt + 1;
                if (!stuck) pc <= pc + 8'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [5:0] d, input logic l);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        #1 chk("load_ready_acc", load_ready, 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", done, 1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cpu_rst", cpu_rst, 0);
        chk("rst_en", cpu_clk_en, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_cycles", cycles, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;

        load_word(6'h01, 0);
        load_word(6'h06, 0);
        load_word(6'h3F, 1);
        @(negedge clk);
        chk("len3", dut.prog_len, 3);
        chk("wr_ptr0", dut.wr_ptr, 0);
        chk("ready_after3", load_ready, 1);

        base = en_cnt;
        do_start();
        @(negedge clk);
        chk("rc_cpu_rst", cpu_rst, 1);
        chk("rc_en", cpu_clk_en, 1);
        chk("rc_busy", busy, 1);
        chk("rc_instr", instr, 0);
        @(negedge clk);
        chk("run_i0", instr, 6'h01);
        chk("run_rst_low", cpu_rst, 0);
        @(negedge clk);
        chk("run_i1", instr, 6'h06);
        @(negedge clk);
        chk("run_i2", instr, 6'h3F);
        wait_done();
        chk("run_en", en_cnt - base, 3);
        chk("run_cycles", cycles, 3);
        chk("run_timeout", timeout, 0);
        chk("run_busy", busy, 0);

        for (int i = 0; i < 16; i++) load_word(6'(i * 5 + 2), 0);
        @(negedge clk);
        chk("len16", dut.prog_len, 16);
        chk("wr_ptr16", dut.wr_ptr, 0);
        load_word(6'h15, 0);
        @(negedge clk);
        chk("wr_ptr17", dut.wr_ptr, 1);
        chk("len17", dut.prog_len, 16);

        stuck = 1'b1;
        base = en_cnt;
        do_start();
        wait_done();
        chk("to_en", en_cnt - base, 200);
        chk("to_cycles", cycles, 200);
        chk("to_timeout", timeout, 1);
        chk("to_instr", instr, 6'h15);
        stuck = 1'b0;

        load_word(6'h0A, 0);
        load_word(6'h0B, 1);
        @(negedge clk);
        chk("len_partial", dut.prog_len, 3);
        base = en_cnt;
        do_start();
        @(negedge clk);
        chk("to_clr", timeout, 0);
        @(negedge clk);
        chk("h_en0", cpu_clk_en, 1);
        @(negedge clk);
        chk("h_en1", cpu_clk_en, 1);
        @(negedge clk);
        halt_req = 1'b1;
        #1 chk("h_en_req", cpu_clk_en, 0);
        @(posedge clk);
        #1 halt_req = 1'b0;
        @(negedge clk);
        chk("h_busy", busy, 1);
        chk("h_instr", instr, 6'h0B);
        step = 1'b1;
        #1 chk("h_en_step", cpu_clk_en, `ifdef HIDDEN_SEQ_STEP_EN 1 `else 0 `endif);
        @(posedge clk);
        #1 step = 1'b0;
`ifdef HIDDEN_SEQ_STEP_EN
        @(negedge clk);
        chk("h_en_post", cpu_clk_en, 0);
        chk("h_cycles", cycles, 3);
        step = 1'b1;
        #1 chk("h_en_end", cpu_clk_en, 0);
        @(posedge clk);
        #1 step = 1'b0;
        @(negedge clk);
        chk("h_step_done", done, 1);
        chk("h_step_cyc", cycles, 3);
`else
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("h_en_idle", cpu_clk_en, 0);
        end
        chk("h_cnt", en_cnt - base, 2);
        chk("h_cycles", cycles, 2);
        do_start();
        wait_done();
        chk("h_fin_cycles", cycles, 3);
        chk("h_fin_en", en_cnt - base, 3);
        chk("h_fin_to", timeout, 0);
`endif

        do_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_en", cpu_clk_en, 0);
        chk("ar_cpu_rst", cpu_rst, 0);
        chk("ar_instr", instr, 0);
        chk("ar_ready", load_ready, 1);
        chk("ar_cycles", cycles, 0);
        @(negedge clk);
        rst = 1'b1;
        do_start();
        @(negedge clk);
        chk("ar_ign_busy", busy, 0);
        chk("ar_ign_rst", cpu_rst, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
